// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: opcodes, FSM states and
// the per-opcode register write policy.
package wb_pkg;

    localparam logic [3:0] OP_CMP = 4'b0100;
    localparam logic [3:0] OP_BR  = 4'b0101;
    localparam logic [3:0] OP_LD  = 4'b0110;
    localparam logic [3:0] OP_ST  = 4'b0111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2
    } wb_state_t;

    // True for opcodes that write in_alu to the register file on acceptance.
    // Compares/branches write nothing; loads write later from memory.
    function automatic logic is_reg_write(input logic [3:0] op);
        return !((op == OP_CMP) || (op == OP_BR) || (op == OP_LD) || (op == OP_ST));
    endfunction

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/wb_regfile.sv
// Architectural register file: one write port, two asynchronous read ports.
// With WB_BYPASS_EN defined, a read whose address matches the write landing
// at the next edge returns the write data in the same cycle.
module wb_regfile #(
    parameter int DATA_W = 16,
    parameter int REG_N  = 8,
    localparam int REG_AW = $clog2(REG_N)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_AW-1:0] raddr_a_i,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] regs_q [REG_N];

    // Register storage; every register (r0 included) is writable and clears on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < REG_N; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

`ifdef WB_BYPASS_EN
    assign rdata_a_o = (we_i && (waddr_i == raddr_a_i)) ? wdata_i : regs_q[raddr_a_i];
    assign rdata_b_o = (we_i && (waddr_i == raddr_b_i)) ? wdata_i : regs_q[raddr_b_i];
`else
    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];
`endif

endmodule

// File: rtl/wb_stage_p.sv
// Write-back stage: retires one instruction at a time, owns the register
// file and drives a request/grant data-memory port for loads and stores.
// Optional feature macro: WB_BYPASS_EN (write-to-read bypass in wb_regfile).
module wb_stage_p
    import wb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int REG_N  = 8,
    parameter int OP_W   = 4,
    localparam int REG_AW = $clog2(REG_N)
) (
    input  logic              clk_wb,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [REG_AW-1:0] in_dr_addr,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_imm,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [REG_AW-1:0] sr_addr,
    input  logic [REG_AW-1:0] tr_addr,
    output logic [DATA_W-1:0] sr_data,
    output logic [DATA_W-1:0] tr_data,
    output logic              retire_valid
);

    wb_state_t         state_q, state_d;
    logic              st_q, st_d;
    logic [REG_AW-1:0] dr_q, dr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              retire_q, retire_d;

    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [3:0]        op4;
    logic              accept;

    assign op4    = 4'(in_op);
    assign accept = in_valid && (state_q == IDLE);

    // Next-state, memory-op latches, register write port and retire pulse.
    always_comb begin
        state_d  = state_q;
        st_d     = st_q;
        dr_d     = dr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        retire_d = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = in_dr_addr;
        rf_wdata = in_alu;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_mem_op(op4)) begin
                        st_d    = (op4 == OP_ST);
                        dr_d    = in_dr_addr;
                        addr_d  = in_imm[ADDR_W-1:0];
                        wdata_d = in_alu;
                        state_d = MEM_REQ;
                    end else begin
                        rf_we    = is_reg_write(op4);
                        retire_d = 1'b1;
                    end
                end
            end
            MEM_REQ: begin
                if (mem_gnt) begin
                    if (st_q) begin
                        state_d  = IDLE;
                        retire_d = 1'b1;
                    end else begin
                        state_d = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_rvalid) begin
                    rf_we    = 1'b1;
                    rf_waddr = dr_q;
                    rf_wdata = mem_rdata;
                    retire_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched memory operation and retire pulse; reset abandons any transaction.
    always_ff @(posedge clk_wb or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            st_q     <= 1'b0;
            dr_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            retire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            st_q     <= st_d;
            dr_q     <= dr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            retire_q <= retire_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign mem_req      = (state_q == MEM_REQ);
    assign mem_we       = st_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign retire_valid = retire_q;

    wb_regfile #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N)
    ) u_regfile (
        .clk_i     (clk_wb),
        .rst_ni    (rst_n),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata),
        .raddr_a_i (sr_addr),
        .raddr_b_i (tr_addr),
        .rdata_a_o (sr_data),
        .rdata_b_o (tr_data)
    );

endmodule

// File: tb/tb_wb_stage_p.sv
// Randomised scoreboard bench for wb_stage_p: expected retires and memory
// requests are queued at issue and consumed by an independent monitor.
module tb_wb_stage_p;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int REG_N  = 8;
    localparam int OP_W   = 4;
    localparam int RAW    = 3;

    logic              clk_wb = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic [RAW-1:0]    in_dr_addr;
    logic [DATA_W-1:0] in_alu;
    logic [DATA_W-1:0] in_imm;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic [RAW-1:0]    sr_addr;
    logic [RAW-1:0]    tr_addr;
    logic [DATA_W-1:0] sr_data;
    logic [DATA_W-1:0] tr_data;
    logic              retire_valid;

    always #5 clk_wb = ~clk_wb;

    wb_stage_p #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .REG_N  (REG_N),
        .OP_W   (OP_W)
    ) dut (
        .clk_wb       (clk_wb),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_dr_addr   (in_dr_addr),
        .in_alu       (in_alu),
        .in_imm       (in_imm),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .sr_addr      (sr_addr),
        .tr_addr      (tr_addr),
        .sr_data      (sr_data),
        .tr_data      (tr_data),
        .retire_valid (retire_valid)
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mreq_t;

    mreq_t       exp_mem[$];
    int          exp_ret[$];
    logic [15:0] model[8];
    int          total  = 0;
    int          passed = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // Monitor: consumes expected retires and memory requests as the DUT presents them.
    always @(negedge clk_wb) begin
        if (rst_n === 1'b1) begin
            if (retire_valid) begin
                chk("retire_expected", 32'(exp_ret.size() > 0), 32'd1);
                if (exp_ret.size() > 0) void'(exp_ret.pop_front());
            end
            if (mem_req && mem_gnt) begin
                chk("memreq_expected", 32'(exp_mem.size() > 0), 32'd1);
                if (exp_mem.size() > 0) begin
                    mreq_t m;
                    m = exp_mem.pop_front();
                    chk("mem_we", 32'(mem_we), 32'(m.we));
                    chk("mem_addr", 32'(mem_addr), 32'(m.addr));
                    chk("mem_wdata", 32'(mem_wdata), 32'(m.wdata));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_wb);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_op    = '0;
    endtask

    function automatic logic writes_alu(input logic [3:0] op);
        return !(op == 4'b0100 || op == 4'b0101 || op == 4'b0110 || op == 4'b0111);
    endfunction

    // Non-memory instruction; leaves in_valid high so calls can be issued back to back.
    task automatic alu_op(input logic [3:0] op, input logic [2:0] dr, input logic [15:0] alu);
        chk("in_ready_alu", 32'(in_ready), 32'd1);
        in_valid   = 1'b1;
        in_op      = op;
        in_dr_addr = dr;
        in_alu     = alu;
        in_imm     = 16'($urandom);
        exp_ret.push_back(int'(op));
        tick();
        if (writes_alu(op)) model[dr] = alu;
        chk("retire_alu", 32'(retire_valid), 32'd1);
    endtask

    task automatic mem_op(input logic st, input logic [2:0] dr, input logic [15:0] imm,
                          input logic [15:0] alu, input int gd, input int rd,
                          input logic [15:0] rv);
        chk("in_ready_mem", 32'(in_ready), 32'd1);
        in_valid   = 1'b1;
        in_op      = st ? 4'b0111 : 4'b0110;
        in_dr_addr = dr;
        in_alu     = alu;
        in_imm     = imm;
        exp_ret.push_back(int'(in_op));
        exp_mem.push_back('{we: st, addr: imm, wdata: alu});
        tick();
        idle();
        for (int i = 0; i < gd; i++) begin
            chk("req_held", 32'(mem_req), 32'd1);
            chk("ready_low_req", 32'(in_ready), 32'd0);
            chk("addr_stable", 32'(mem_addr), 32'(imm));
            chk("wdata_stable", 32'(mem_wdata), 32'(alu));
            tick();
        end
        chk("req_at_gnt", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        if (st) begin
            chk("retire_store", 32'(retire_valid), 32'd1);
            chk("ready_after_st", 32'(in_ready), 32'd1);
        end else begin
            chk("req_dropped", 32'(mem_req), 32'd0);
            for (int i = 0; i < rd; i++) begin
                chk("ready_low_wait", 32'(in_ready), 32'd0);
                chk("no_early_retire", 32'(retire_valid), 32'd0);
                tick();
            end
            mem_rvalid = 1'b1;
            mem_rdata  = rv;
            tick();
            mem_rvalid = 1'b0;
            model[dr]  = rv;
            chk("retire_load", 32'(retire_valid), 32'd1);
            chk("ready_after_ld", 32'(in_ready), 32'd1);
        end
    endtask

    task automatic read_check(input logic [2:0] a, input logic [2:0] b);
        sr_addr = a;
        tr_addr = b;
        #1;
        chk("sr_data", 32'(sr_data), 32'(model[a]));
        chk("tr_data", 32'(tr_data), 32'(model[b]));
    endtask

    task automatic check_all();
        for (int i = 0; i < 8; i += 2) read_check(3'(i), 3'(i + 1));
    endtask

    initial begin
        logic [3:0]  op;
        logic [15:0] bypass_exp;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_op      = '0;
        in_dr_addr = '0;
        in_alu     = '0;
        in_imm     = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        sr_addr    = '0;
        tr_addr    = '0;
        for (int i = 0; i < 8; i++) model[i] = '0;

        tick();
        tick();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_retire", 32'(retire_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", 32'(in_ready), 32'd1);
        check_all();

        // ALU burst on consecutive cycles
        alu_op(4'b0000, 3'd1, 16'h1234);
        alu_op(4'b0000, 3'd2, 16'hBEEF);
        idle();
        read_check(3'd1, 3'd2);
        tick();

        // Store with grant delay, then load with rvalid two cycles after grant
        mem_op(1'b1, 3'd0, 16'h0040, 16'h00AA, 3, 0, 16'h0000);
        mem_op(1'b0, 3'd5, 16'h0040, 16'h0000, 1, 1, 16'h00AA);
        read_check(3'd5, 3'd1);

        // Stray rvalid in IDLE is ignored
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hDEAD;
        tick();
        mem_rvalid = 1'b0;
        chk("stray_no_retire", 32'(retire_valid), 32'd0);
        check_all();

        // Compare/branch write nothing but retire
        alu_op(4'b0100, 3'd3, 16'hFFFF);
        alu_op(4'b0101, 3'd3, 16'hFFFF);
        idle();
        read_check(3'd3, 3'd3);
        tick();

        // Read-during-write on r4
        alu_op(4'b0000, 3'd4, 16'h1111);
        idle();
        tick();
        sr_addr    = 3'd4;
        tr_addr    = 3'd1;
        in_valid   = 1'b1;
        in_op      = 4'b0000;
        in_dr_addr = 3'd4;
        in_alu     = 16'h5555;
`ifdef WB_BYPASS_EN
        bypass_exp = 16'h5555;
`else
        bypass_exp = 16'h1111;
`endif
        #1;
        chk("bypass_sr", 32'(sr_data), 32'(bypass_exp));
        exp_ret.push_back(0);
        tick();
        model[4] = 16'h5555;
        chk("retire_bypass_op", 32'(retire_valid), 32'd1);
        idle();
        read_check(3'd4, 3'd4);
        tick();

        // Randomised instruction mix
        for (int n = 0; n < 80; n++) begin
            int k;
            k = int'($urandom_range(0, 5));
            if (k <= 2) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'b0110 || op == 4'b0111) op = 4'b0001;
                alu_op(op, 3'($urandom), 16'($urandom));
                if ($urandom_range(0, 1) == 0) begin
                    idle();
                    tick();
                end
            end else if (k == 3) begin
                idle();
                mem_op(1'b1, 3'($urandom), 16'($urandom), 16'($urandom),
                       int'($urandom_range(0, 3)), 0, 16'h0);
            end else if (k == 4) begin
                idle();
                mem_op(1'b0, 3'($urandom), 16'($urandom), 16'($urandom),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                       16'($urandom));
            end else begin
                idle();
                read_check(3'($urandom), 3'($urandom));
                tick();
            end
        end
        idle();
        tick();
        check_all();

        // Reset while a load waits for data
        tick();
        in_valid   = 1'b1;
        in_op      = 4'b0110;
        in_dr_addr = 3'd6;
        in_imm     = 16'h0080;
        in_alu     = 16'h0000;
        exp_mem.push_back('{we: 1'b0, addr: 16'h0080, wdata: 16'h0000});
        tick();
        idle();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) model[i] = '0;
        chk("rst_mid_req", 32'(mem_req), 32'd0);
        chk("rst_mid_retire", 32'(retire_valid), 32'd0);
        check_all();
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h7777;
        rst_n      = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk("late_rvalid_retire", 32'(retire_valid), 32'd0);
        chk("ready_after_mid_rst", 32'(in_ready), 32'd1);
        check_all();

        repeat (3) tick();
        chk("retire_queue_empty", 32'(exp_ret.size()), 32'd0);
        chk("mem_queue_empty", 32'(exp_mem.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
